dcache_ctrl: RTL and testbench

//  Memory-side responder for the CPU load/store port (MemRead/MemWrite, addr, w_data, r_data).

---
 rtl/dcache_pkg.sv | 32 +++
 rtl/dcache_sram.sv | 55 +++++
 rtl/dcache_ctrl.sv | 115 +++++++++++
 tb/tb_dcache_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared widths, FSM states and tag-entry payload for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int unsigned NUM_LINES  = 32;
    localparam int unsigned LINE_BYTES = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned INDEX_W    = $clog2(NUM_LINES);
    localparam int unsigned OFFSET_W   = $clog2(LINE_BYTES);
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_W     = 8 * LINE_BYTES;
    localparam int unsigned WSEL_W     = OFFSET_W - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    // Extract one 32-bit word from a line; bit offset is sel*32.
    function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                   input logic [WSEL_W-1:0] sel);
        return line[{sel, 5'd0} +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty array plus line data array: asynchronous read, synchronous write.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [INDEX_W-1:0]   idx_i,
    output tag_entry_t           rd_entry_o,
    output logic [LINE_W-1:0]    rd_line_o,
    input  logic                 line_we_i,
    input  logic [TAG_W-1:0]     line_tag_i,
    input  logic [LINE_W-1:0]    line_data_i,
    input  logic                 word_we_i,
    input  logic                 word_dirty_i,
    input  logic [WSEL_W-1:0]    word_sel_i,
    input  logic [WORD_W-1:0]    word_data_i
);

    tag_entry_t        entry_q [NUM_LINES];
    tag_entry_t        entry_d [NUM_LINES];
    logic [LINE_W-1:0] data_q  [NUM_LINES];
    logic [LINE_W-1:0] data_d  [NUM_LINES];

    assign rd_entry_o = entry_q[idx_i];
    assign rd_line_o  = data_q[idx_i];

    // Refill installs a clean valid line; a word write merges and optionally marks dirty.
    always_comb begin
        entry_d = entry_q;
        data_d  = data_q;
        if (line_we_i) begin
            entry_d[idx_i] = '{valid: 1'b1, dirty: 1'b0, tag: line_tag_i};
            data_d[idx_i]  = line_data_i;
        end else if (word_we_i) begin
            data_d[idx_i][{word_sel_i, 5'd0} +: WORD_W] = word_data_i;
            if (word_dirty_i) begin
                entry_d[idx_i].dirty = 1'b1;
            end
        end
    end

    // Only valid/dirty are reset; tags and data keep whatever they held.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        if (rst_i) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                entry_q[i].valid <= 1'b0;
                entry_q[i].dirty <= 1'b0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller in place of the CPU data memory.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [WORD_W-1:0]   w_data_i,
    input  logic                MemRead_i,
    input  logic                MemWrite_i,
    output logic [WORD_W-1:0]   r_data_o,
    output logic                stall_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [LINE_W-1:0]   mem_wdata_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    input  logic [LINE_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i
);

    state_e             state_q;
    state_e             state_d;
    tag_entry_t         rd_entry;
    logic [LINE_W-1:0]  rd_line;
    logic               line_we;
    logic               word_we;
    logic               req;
    logic               hit;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [WSEL_W-1:0]  wsel;
    logic               unused_addr;

    assign idx         = addr_i[OFFSET_W +: INDEX_W];
    assign tag         = addr_i[ADDR_W-1 -: TAG_W];
    assign wsel        = addr_i[OFFSET_W-1:2];
    assign unused_addr = ^addr_i[1:0];
    assign req         = MemRead_i | MemWrite_i;
    assign hit         = rd_entry.valid && (rd_entry.tag == tag);

    dcache_sram u_sram (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .idx_i        (idx),
        .rd_entry_o   (rd_entry),
        .rd_line_o    (rd_line),
        .line_we_i    (line_we),
        .line_tag_i   (tag),
        .line_data_i  (mem_rdata_i),
        .word_we_i    (word_we),
        .word_dirty_i (1'b1),
        .word_sel_i   (wsel),
        .word_data_i  (w_data_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, hit servicing and memory-side request generation.
    always_comb begin
        state_d      = state_q;
        stall_o      = 1'b0;
        r_data_o     = '0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        line_we      = 1'b0;
        word_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (MemWrite_i) begin
                            word_we = 1'b1;
                        end else begin
                            r_data_o = get_word(rd_line, wsel);
                        end
                    end else begin
                        stall_o = 1'b1;
                        state_d = (rd_entry.valid && rd_entry.dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                stall_o      = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_entry.tag, idx, {OFFSET_W{1'b0}}};
                mem_wdata_o  = rd_line;
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                stall_o      = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    line_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench: bench acts as line memory; model tracks latest CPU-visible values and line residency.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [31:0]  w_data_i;
    logic         MemRead_i;
    logic         MemWrite_i;
    logic [31:0]  r_data_o;
    logic         stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem  [int unsigned];
    logic [31:0] gold [int unsigned];
    bit          res_valid [32];
    bit          res_dirty [32];
    logic [21:0] res_tag   [32];

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .addr_i       (addr_i),
        .w_data_i     (w_data_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .r_data_o     (r_data_o),
        .stall_o      (stall_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ensure(input int unsigned w);
        logic [31:0] v;
        if (!gold.exists(w)) begin
            v       = $urandom;
            gold[w] = v;
            mem[w]  = v;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
        end
        foreach (gold[k]) gold[k] = mem[k];
    endtask

    // One memory transaction: enable held for delay cycles, ack on the last.
    task automatic serve(input bit wr, input logic [31:0] la, input int delay, input logic [255:0] line);
        for (int c = 0; c <= delay; c++) begin
            @(negedge clk);
            mem_ack_i   = (c == delay);
            mem_rdata_i = (c == delay && !wr) ? line : '0;
            #1;
            check("mem_enable", mem_enable_o, 1'b1);
            check("mem_write", mem_write_o, wr);
            check("mem_addr", mem_addr_o, la);
            check("stall_busy", stall_o, 1'b1);
            if (wr) check("wb_data", mem_wdata_o, line);
        end
    endtask

    task automatic do_access(input logic [31:0] a, input bit rd, input bit wr,
                             input logic [31:0] wd, input int delay);
        logic [4:0]   idx;
        logic [21:0]  tg;
        logic [31:0]  la;
        logic [31:0]  vla;
        int unsigned  w;
        int unsigned  vw;
        bit           hit;
        logic [255:0] l;
        idx = a[9:5];
        tg  = a[31:10];
        la  = {a[31:5], 5'b0};
        w   = a >> 2;
        @(negedge clk);
        mem_ack_i  = 1'b0;
        addr_i     = a;
        MemRead_i  = rd;
        MemWrite_i = wr;
        w_data_i   = wd;
        hit = res_valid[idx] && (res_tag[idx] == tg);
        #1;
        if (!hit) begin
            check("miss_stall", stall_o, 1'b1);
            check("miss_idle_enable", mem_enable_o, 1'b0);
            if (res_valid[idx] && res_dirty[idx]) begin
                vla = {res_tag[idx], idx, 5'b0};
                vw  = vla >> 2;
                for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold[vw + i];
                serve(1'b1, vla, delay, l);
                for (int i = 0; i < 8; i++) mem[vw + i] = l[i*32 +: 32];
            end
            for (int i = 0; i < 8; i++) begin
                ensure((la >> 2) + i);
                l[i*32 +: 32] = mem[(la >> 2) + i];
            end
            serve(1'b0, la, delay, l);
            res_valid[idx] = 1'b1;
            res_dirty[idx] = 1'b0;
            res_tag[idx]   = tg;
            @(negedge clk);
            mem_ack_i = 1'b0;
            #1;
        end
        check("hit_stall", stall_o, 1'b0);
        check("hit_enable", mem_enable_o, 1'b0);
        if (rd && !wr) check("load_data", r_data_o, gold[w]);
        if (wr) begin
            gold[w]        = wd;
            res_dirty[idx] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        rst_i       = 1'b1;
        addr_i      = '0;
        w_data_i    = '0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        mem_rdata_i = '0;
        mem_ack_i   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_stall", stall_o, 1'b0);
        check("rst_enable", mem_enable_o, 1'b0);
        check("rst_write", mem_write_o, 1'b0);
        check("rst_rdata", r_data_o, 32'h0);

        // Cold load miss, then store hit, load-back, dirty conflict, delayed clean conflict.
        gold[32'h10] = 32'hDEADBEEF;
        mem[32'h10]  = 32'hDEADBEEF;
        do_access(32'h0000_0040, 1'b1, 1'b0, 32'h0, 0);
        do_access(32'h0000_0044, 1'b0, 1'b1, 32'h1234_5678, 0);
        do_access(32'h0000_0044, 1'b1, 1'b0, 32'h0, 0);
        do_access(32'h0000_0440, 1'b1, 1'b0, 32'h0, 1);
        do_access(32'h0000_0840, 1'b1, 1'b0, 32'h0, 10);

        // Reset in the third ALLOCATE cycle abandons the fetch.
        @(negedge clk);
        addr_i = 32'h0000_0C40; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        #1;
        check("rstmid_stall", stall_o, 1'b1);
        @(negedge clk); #1;
        check("rstmid_alloc1", mem_enable_o, 1'b1);
        @(negedge clk); #1;
        check("rstmid_alloc2", mem_enable_o, 1'b1);
        @(negedge clk);
        rst_i = 1'b1; MemRead_i = 1'b0;
        #1;
        check("rstmid_alloc3", mem_enable_o, 1'b1);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rstmid_enable", mem_enable_o, 1'b0);
        check("rstmid_stall_low", stall_o, 1'b0);
        model_reset();
        do_access(32'h0000_0C40, 1'b1, 1'b0, 32'h0, 0);

        // Spurious ack with no request.
        @(negedge clk);
        MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = '1;
        #1;
        check("idle_stall", stall_o, 1'b0);
        check("idle_enable", mem_enable_o, 1'b0);
        check("idle_write", mem_write_o, 1'b0);
        check("idle_rdata", r_data_o, 32'h0);
        check("idle_addr", mem_addr_o, 32'h0);
        check("idle_wdata", mem_wdata_o, 256'h0);
        @(negedge clk);
        mem_ack_i = 1'b0;
        do_access(32'h0000_0C44, 1'b1, 1'b0, 32'h0, 0);

        // Top-of-memory line.
        do_access(32'hFFFF_FFFC, 1'b0, 1'b1, 32'hA5A5_0F0F, 2);
        do_access(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 0);

        // Random mix over a few tags/indices to force conflicts and writebacks.
        for (int n = 0; n < 300; n++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
              | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            op = $urandom_range(0, 3);
            do_access(a, (op != 2), (op >= 2), $urandom, $urandom_range(0, 3));
        end

        @(negedge clk);
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
